// File: rtl/de1_soc_key_pkg.sv
// Shared constants for the DE1-SoC key debouncer: defaults, FSM encoding and a
// constant-evaluable clog2 used to size the stability counter.
package de1_soc_key_pkg;

  localparam int KEY_NUM_DEFAULT    = 4;
  localparam int KEY_STABLE_DEFAULT = 500000;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  typedef enum logic {
    KS_IDLE  = ST_IDLE,
    KS_COUNT = ST_COUNT
  } key_state_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/de1_soc_key_debounce_ch.sv
// One key channel: 2-flop synchronizer, stability FSM/counter, optional edge pulses.
// Edge pulses are built only when DE1_SOC_KEY_EDGE_PULSE_EN is defined.
module de1_soc_key_debounce_ch
  import de1_soc_key_pkg::*;
#(
  parameter int   STABLE_CYCLES = KEY_STABLE_DEFAULT,
  parameter logic RST_VAL       = 1'b1,
  parameter logic INVERT        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2, p;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_state_e       state_q, state_d;

  // Sync flops reset to the released pin value so no press is seen at reset exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  assign p = s2 ^ INVERT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      KS_IDLE: begin
        cnt_d = '0;
        if (p != level_q) begin
          // A single-cycle qualification window flips immediately.
          if (CNT_LAST == '0) begin
            level_d = p;
          end else begin
            state_d = KS_COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      KS_COUNT: begin
        if (p == level_q) begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = p;
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = KS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level = level_q;

`ifdef DE1_SOC_KEY_EDGE_PULSE_EN
  logic level_d1, press_q, release_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d1  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_d1  <= level_q;
      press_q   <= level_q & ~level_d1;
      release_q <= ~level_q & level_d1;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
`else
  assign key_press   = 1'b0;
  assign key_release = 1'b0;
`endif

endmodule

// File: rtl/de1_soc_key_debounce.sv
// DE1-SoC KEY[] conditioner: NUM_KEYS independent debounce channels feeding the keys PIO.
// key_press/key_release are live only with DE1_SOC_KEY_EDGE_PULSE_EN defined.
module de1_soc_key_debounce
  import de1_soc_key_pkg::*;
#(
  parameter int NUM_KEYS      = KEY_NUM_DEFAULT,
  parameter int STABLE_CYCLES = KEY_STABLE_DEFAULT,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic POL = ACTIVE_LOW ? 1'b1 : 1'b0;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    de1_soc_key_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RST_VAL       (POL),
      .INVERT        (POL)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_raw     (key_raw[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g])
    );
  end

endmodule

// File: tb/tb_de1_soc_key_debounce.sv
// Directed bench for de1_soc_key_debounce (STABLE_CYCLES = 8, ACTIVE_LOW = 1).
// Pulse checks follow DE1_SOC_KEY_EDGE_PULSE_EN: live pulses when defined, constant 0 otherwise.
module tb_de1_soc_key_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_level, key_press, key_release;
  int vec = 0;
  int errs = 0;

`ifdef DE1_SOC_KEY_EDGE_PULSE_EN
  localparam bit PULSES = 1'b1;
`else
  localparam bit PULSES = 1'b0;
`endif

  always #10 clk = ~clk;

  de1_soc_key_debounce #(.NUM_KEYS(4), .STABLE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_raw = 4'hF;
    idle(3);
    vec++;
    if (key_level !== 4'h0 || key_press !== 4'h0 || key_release !== 4'h0) begin
      errs++; $display("FAIL reset_hold: level=%h press=%h rel=%h want 0/0/0", key_level, key_press, key_release);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      vec++;
      if (key_level !== 4'h0 || key_press !== 4'h0) begin
        errs++; $display("FAIL reset_quiet c%0d: level=%h press=%h want 0/0", k, key_level, key_press);
      end
    end
  endtask

  // Level rises on the 10th edge counting the first sampling edge; press one edge later.
  task automatic test_single_press();
    logic [3:0] exp_lvl, exp_prs;
    key_raw = 4'hE;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 10) ? 4'h1 : 4'h0;
      exp_prs = (PULSES && k == 11) ? 4'h1 : 4'h0;
      vec++;
      if (key_level !== exp_lvl || key_press !== exp_prs || key_release !== 4'h0) begin
        errs++; $display("FAIL single_press c%0d: level=%h press=%h rel=%h want %h/%h/0",
                         k, key_level, key_press, key_release, exp_lvl, exp_prs);
      end
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 10) ? 4'h0 : 4'h1;
      exp_prs = (PULSES && k == 11) ? 4'h1 : 4'h0;
      vec++;
      if (key_level !== exp_lvl || key_release !== exp_prs || key_press !== 4'h0) begin
        errs++; $display("FAIL single_release c%0d: level=%h rel=%h press=%h want %h/%h/0",
                         k, key_level, key_release, key_press, exp_lvl, exp_prs);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 6; k++) begin
        key_raw = (k < 5) ? 4'hD : 4'hF;
        @(negedge clk);
        vec++;
        if (key_level !== 4'h0 || key_press !== 4'h0) begin
          errs++; $display("FAIL bounce r%0d c%0d: level=%h press=%h want 0/0", r, k, key_level, key_press);
        end
      end
    end
    key_raw = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vec++;
      if (key_level !== 4'h0) begin
        errs++; $display("FAIL bounce_tail c%0d: level=%h want 0", k, key_level);
      end
    end
  endtask

  task automatic test_all_keys();
    logic [3:0] exp_lvl, exp_p;
    key_raw = 4'h0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 10) ? 4'hF : 4'h0;
      exp_p   = (PULSES && k == 11) ? 4'hF : 4'h0;
      vec++;
      if (key_level !== exp_lvl || key_press !== exp_p) begin
        errs++; $display("FAIL all_press c%0d: level=%h press=%h want %h/%h", k, key_level, key_press, exp_lvl, exp_p);
      end
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 10) ? 4'h0 : 4'hF;
      exp_p   = (PULSES && k == 11) ? 4'hF : 4'h0;
      vec++;
      if (key_level !== exp_lvl || key_release !== exp_p || key_press !== 4'h0) begin
        errs++; $display("FAIL all_release c%0d: level=%h rel=%h press=%h want %h/%h/0",
                         k, key_level, key_release, key_press, exp_lvl, exp_p);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [3:0] exp_lvl;
    key_raw = 4'hB;
    idle(7);  // counter on key 2 has reached 5
    vec++;
    if (key_level !== 4'h0) begin
      errs++; $display("FAIL midcount_pre: level=%h want 0", key_level);
    end
    reset_n = 1'b0;
    idle(2);
    vec++;
    if (key_level !== 4'h0 || key_press !== 4'h0) begin
      errs++; $display("FAIL midcount_rst: level=%h press=%h want 0/0", key_level, key_press);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 10) ? 4'h4 : 4'h0;
      vec++;
      if (key_level !== exp_lvl) begin
        errs++; $display("FAIL midcount_requal c%0d: level=%h want %h", k, key_level, exp_lvl);
      end
    end
    key_raw = 4'hF;
    idle(14);
    vec++;
    if (key_level !== 4'h0) begin
      errs++; $display("FAIL midcount_release: level=%h want 0", key_level);
    end
  endtask

  initial begin
    fork
      begin
        @(negedge clk);
        test_reset();
        test_single_press();
        idle(5);
        test_bounce();
        test_all_keys();
        idle(5);
        test_reset_midcount();
      end
      begin
        repeat (20000) @(posedge clk);
        errs++;
        $display("FAIL timeout: bench exceeded 20000 cycles");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
